// File: rtl/pipe_ctrl_pkg.sv
// Shared types and select codes for the pipeline forwarding/hazard control slice.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RSVD  = 2'b11;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } shadow_ent_t;

  localparam shadow_ent_t BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it can never feed a consumer.
  function automatic logic ent_match(input shadow_ent_t ent,
                                     input logic [REG_ADDR_W_DEF-1:0] src,
                                     input logic use_src,
                                     input logic id_valid);
    return use_src && id_valid && ent.valid && ent.regwrite &&
           (ent.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side inputs and datapath control outputs of the forwarding/hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;
  logic                  ext_stall;

  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic                  load_use_stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, flush, ext_stall,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble,
           load_use_stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, flush, ext_stall,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble,
           load_use_stall, stall_count
  );
endinterface

// File: rtl/fwd_sel_calc.sv
// Per-operand forward select: nearest in-flight writer wins; flags a hit on an EX load.
module fwd_sel_calc
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  shadow_ent_t           ex_ent,
  input  shadow_ent_t           mem_ent,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic ex_match;
  logic mem_match;
  logic unused_mem_ld;

  assign ex_match      = ent_match(ex_ent, src, use_src, id_valid);
  assign mem_match     = ent_match(mem_ent, src, use_src, id_valid);
  assign unused_mem_ld = mem_ent.memread;

  always_comb begin
    sel      = FWD_REG;
    load_hit = 1'b0;
    if (ex_match) begin
      sel      = FWD_EXMEM;
      load_hit = ex_ent.memread;
    end else if (mem_match) begin
      sel      = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadow EX/MEM/WB destination pipe, operand
// forward selects, load-use stall, flush bubble and external freeze handling.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_ctrl_if.slave  bus
);

  shadow_ent_t      id_ent_p0;
  shadow_ent_t      ex_ent_p1;
  shadow_ent_t      mem_ent_p2;
  shadow_ent_t      wb_ent_p3;
  logic [1:0]       sel_a_p0;
  logic [1:0]       sel_b_p0;
  logic             load_hit_a;
  logic             load_hit_b;
  logic [1:0]       fwd_a_sel_p1;
  logic [1:0]       fwd_b_sel_p1;
  logic [CNT_W-1:0] stall_count_p1;
  logic             load_use_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             unused_wb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- p0: ID evaluation against the in-flight EX/MEM writers ----
  always_comb begin
    id_ent_p0          = BUBBLE;
    id_ent_p0.valid    = bus.id_valid;
    id_ent_p0.rd       = bus.id_rd;
    id_ent_p0.regwrite = bus.id_regwrite;
    id_ent_p0.memread  = bus.id_memread;
  end

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .id_valid (bus.id_valid),
    .src      (bus.id_rs),
    .use_src  (bus.id_use_rs),
    .ex_ent   (ex_ent_p1),
    .mem_ent  (mem_ent_p2),
    .sel      (sel_a_p0),
    .load_hit (load_hit_a)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .id_valid (bus.id_valid),
    .src      (bus.id_rt),
    .use_src  (bus.id_use_rt),
    .ex_ent   (ex_ent_p1),
    .mem_ent  (mem_ent_p2),
    .sel      (sel_b_p0),
    .load_hit (load_hit_b)
  );

  // A taken branch kills the dependent instruction, so there is nothing to stall for.
  assign load_use_stall = (load_hit_a | load_hit_b) & ~bus.flush;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if (bus.ext_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (bus.flush) begin
      idex_bubble = 1'b1;
    end else if (load_use_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // ---- p1..p3: shadow pipe advance, registered selects, stall counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ent_p1      <= BUBBLE;
      mem_ent_p2     <= BUBBLE;
      wb_ent_p3      <= BUBBLE;
      fwd_a_sel_p1   <= FWD_REG;
      fwd_b_sel_p1   <= FWD_REG;
      stall_count_p1 <= '0;
    end else if (!bus.ext_stall) begin
      wb_ent_p3    <= mem_ent_p2;
      mem_ent_p2   <= ex_ent_p1;
      ex_ent_p1    <= idex_bubble ? BUBBLE  : id_ent_p0;
      fwd_a_sel_p1 <= idex_bubble ? FWD_REG : sel_a_p0;
      fwd_b_sel_p1 <= idex_bubble ? FWD_REG : sel_b_p0;
      if (load_use_stall) begin
        stall_count_p1 <= sat_inc(stall_count_p1);
      end
    end
  end

  // The WB entry retires the writer; no consumer here needs its fields.
  assign unused_wb = ^wb_ent_p3;

  assign bus.fwd_a_sel      = fwd_a_sel_p1;
  assign bus.fwd_b_sel      = fwd_b_sel_p1;
  assign bus.pc_write       = pc_write;
  assign bus.ifid_write     = ifid_write;
  assign bus.idex_bubble    = idex_bubble;
  assign bus.load_use_stall = load_use_stall;
  assign bus.stall_count    = stall_count_p1;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, then random traffic against a reference model.
module tb_fwd_hazard_ctrl;

  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int SCW = 3;
  localparam int SAT_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW))  bus ();
  fwd_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(SCW)) bus_s ();

  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy to reach the saturation point quickly.
  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(SCW)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.id_valid    = bus.id_valid;
  assign bus_s.id_rs       = bus.id_rs;
  assign bus_s.id_rt       = bus.id_rt;
  assign bus_s.id_use_rs   = bus.id_use_rs;
  assign bus_s.id_use_rt   = bus.id_use_rt;
  assign bus_s.id_rd       = bus.id_rd;
  assign bus_s.id_regwrite = bus.id_regwrite;
  assign bus_s.id_memread  = bus.id_memread;
  assign bus_s.flush       = bus.flush;
  assign bus_s.ext_stall   = bus.ext_stall;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int ea, input int eb, input logic epc, input logic eif,
                           input logic ebub, input logic elus, input int ecnt);
    chk("fwd_a_sel",       32'(bus.fwd_a_sel),      32'(ea));
    chk("fwd_b_sel",       32'(bus.fwd_b_sel),      32'(eb));
    chk("pc_write",        32'(bus.pc_write),       32'(epc));
    chk("ifid_write",      32'(bus.ifid_write),     32'(eif));
    chk("idex_bubble",     32'(bus.idex_bubble),    32'(ebub));
    chk("load_use_stall",  32'(bus.load_use_stall), 32'(elus));
    chk("stall_count",     32'(bus.stall_count),    32'(ecnt));
    chk("stall_count_sat", 32'(bus_s.stall_count),  32'((ecnt > SAT_MAX) ? SAT_MAX : ecnt));
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                       input int rd, input logic rw, input logic mr, input logic fl, input logic ex);
    bus.id_valid    = v;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_rd       = 5'(rd);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.flush       = fl;
    bus.ext_stall   = ex;
  endtask

  typedef struct {
    logic r, v;
    int   rs, rt;
    logic urs, urt;
    int   rd;
    logic rw, mr, fl, ex;
    int   ea, eb;
    logic epc, eif, ebub, elus;
    int   ecnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input int rd, input logic rw,
                              input logic mr, input logic fl, input logic ex, input int ea,
                              input int eb, input logic epc, input logic eif, input logic ebub,
                              input logic elus, input int ecnt);
    vec_t t;
    t.r = r; t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.rd = rd;
    t.rw = rw; t.mr = mr; t.fl = fl; t.ex = ex; t.ea = ea; t.eb = eb;
    t.epc = epc; t.eif = eif; t.ebub = ebub; t.elus = elus; t.ecnt = ecnt;
    return t;
  endfunction

  // Reference model: the three most recent issue slots, youngest first.
  typedef struct { bit v; int rd; bit wr; bit ld; } slot_t;
  slot_t q[3];
  int    m_sel_a, m_sel_b, m_cnt;

  function automatic int producer_dist(input int src, input bit use_src, input bit idv);
    if (!use_src || !idv || src == 0) return 0;
    for (int d = 0; d < 2; d++)
      if (q[d].v && q[d].wr && q[d].rd == src) return d + 1;
    return 0;
  endfunction

  function automatic int dist_to_code(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) q[i] = '{0, 0, 0, 0};
    m_sel_a = 0; m_sel_b = 0; m_cnt = 0;
  endtask

  vec_t vecs[$];

  initial begin
    // Directed table: rows in order, one per clock, state carries across rows.
    // cols: rst v rs rt urs urt rd rw mr fl ex | fwd_a fwd_b pc ifid bub lus cnt
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0)); // reset state
    vecs.push_back(mk(0,1,1,2,1,1,3,1,0,0,0, 0,0,1,1,0,0,0)); // ADD r3
    vecs.push_back(mk(0,1,3,1,1,1,4,1,0,0,0, 0,0,1,1,0,0,0)); // SUB r4,r3,r1
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,1,1,0,0,0)); // SUB in EX: a=01
    vecs.push_back(mk(0,1,1,2,1,1,3,1,0,0,0, 0,0,1,1,0,0,0)); // ADD r3
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0)); // NOP
    vecs.push_back(mk(0,1,1,3,1,1,5,1,0,0,0, 0,0,1,1,0,0,0)); // OR r5,r1,r3
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,2,1,1,0,0,0)); // OR in EX: b=10
    vecs.push_back(mk(0,1,1,2,1,0,2,1,1,0,0, 0,0,1,1,0,0,0)); // LW r2
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,0, 0,0,0,0,1,1,0)); // ADD r6,r2,r2 stalls
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,0, 0,0,1,1,0,0,1)); // re-evaluated
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 2,2,1,1,0,0,1)); // ADD in EX: 10/10
    vecs.push_back(mk(0,1,1,0,1,0,0,1,0,0,0, 0,0,1,1,0,0,1)); // writer of r0
    vecs.push_back(mk(0,1,0,0,1,1,7,1,0,0,0, 0,0,1,1,0,0,1)); // reader of r0
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,1)); // r0 never forwards
    vecs.push_back(mk(0,1,1,2,1,0,2,1,1,0,0, 0,0,1,1,0,0,1)); // LW r2
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,1,0, 0,0,1,1,1,0,1)); // dependent + flush
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,1)); // bubble selects 00
    vecs.push_back(mk(0,1,1,2,1,1,3,1,0,0,0, 0,0,1,1,0,0,1)); // ADD r3
    vecs.push_back(mk(0,1,3,1,1,1,4,1,0,0,1, 0,0,0,0,0,0,1)); // SUB, ext_stall x3
    vecs.push_back(mk(0,1,3,1,1,1,4,1,0,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,1,3,1,1,1,4,1,0,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,1,3,1,1,1,4,1,0,0,0, 0,0,1,1,0,0,1)); // released
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,1,1,0,0,1)); // SUB in EX: a=01
    vecs.push_back(mk(0,1,1,2,1,0,2,1,1,0,0, 0,0,1,1,0,0,1)); // LW r2
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,1, 0,0,0,0,0,1,1)); // load-use under ext_stall
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,0, 0,0,0,0,1,1,1)); // stall now takes effect
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,0, 0,0,1,1,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 2,2,1,1,0,0,2));
    vecs.push_back(mk(0,1,1,2,1,0,2,1,1,0,0, 0,0,1,1,0,0,2)); // LW r2
    vecs.push_back(mk(1,1,2,2,1,1,6,1,0,0,0, 0,0,0,0,1,1,2)); // rst mid-stall
    vecs.push_back(mk(0,1,2,2,1,1,6,1,0,0,0, 0,0,1,1,0,0,0)); // empty pipe again
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r;
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].ex);
      @(negedge clk);
      check_all(vecs[i].ea, vecs[i].eb, vecs[i].epc, vecs[i].eif,
                vecs[i].ebub, vecs[i].elus, vecs[i].ecnt);
      @(posedge clk);
      #1;
    end

    // Random phase from a clean reset.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    begin
      bit v, urs, urt, rw, ld, fl, ex, r, hold;
      int rs, rt, rd, pa, pb;
      bit haz, lus, epc, eif, ebub;
      hold = 0; v = 0; urs = 0; urt = 0; rw = 0; ld = 0; rs = 0; rt = 0; rd = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (!hold) begin
          v   = ($urandom_range(0, 7) != 0);
          rs  = $urandom_range(0, 3);
          rt  = $urandom_range(0, 3);
          rd  = $urandom_range(0, 3);
          urs = $urandom_range(0, 1) == 1;
          urt = $urandom_range(0, 1) == 1;
          ld  = ($urandom_range(0, 2) == 0);
          rw  = ld ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        fl = ($urandom_range(0, 9) == 0);
        ex = ($urandom_range(0, 7) == 0);
        r  = ($urandom_range(0, 79) == 0);
        rst = r;
        drive(v, rs, rt, urs, urt, rd, rw, ld, fl, ex);

        pa   = producer_dist(rs, urs, v);
        pb   = producer_dist(rt, urt, v);
        haz  = ((pa == 1) || (pb == 1)) && q[0].ld;
        lus  = haz && !fl;
        epc  = !ex && (fl || !lus);
        eif  = epc;
        ebub = !ex && (fl || lus);

        @(negedge clk);
        check_all(m_sel_a, m_sel_b, epc, eif, ebub, lus, m_cnt);
        @(posedge clk);
        #1;

        if (r) begin
          model_reset();
        end else if (!ex) begin
          q[2] = q[1];
          q[1] = q[0];
          q[0] = ebub ? '{0, 0, 0, 0} : '{v, rd, rw, ld};
          m_sel_a = ebub ? 0 : dist_to_code(pa);
          m_sel_b = ebub ? 0 : dist_to_code(pb);
          if (lus && m_cnt < 65535) m_cnt++;
        end
        hold = !eif && !r;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It tracks each in-flight instruction's destination register in a shadow pipeline and drives the 2-bit select codes consumed by the EX-stage 4:1 operand muxes. It also drives the load-use stall, bubble and flush controls that keep the datapath coherent. It sits between the ID decode logic and the ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 16: width of the saturating stall counter.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  source register A of the ID instruction.
- id_rt  in  REG_ADDR_W  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction (already muxed rd/rt).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  branch/jump resolved taken in EX; kill the ID instruction.
- ext_stall  in  1  memory wait; freeze the whole pipeline.
- fwd_a_sel  out  2  operand-A mux select, valid during EX.
- fwd_b_sel  out  2  operand-B mux select, valid during EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register update enable.
- idex_bubble  out  1  load NOP into ID/EX this edge.
- load_use_stall  out  1  load-use hazard detected this cycle.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Shadow pipeline has three entries: EX, MEM, WB. Each entry holds {valid, rd, regwrite, memread}.
- Each edge, absent freeze, the shadow pipeline advances: WB<=MEM, MEM<=EX, EX<=ID entry or a bubble.
- Bubble = entry with valid=0. EX takes a bubble when idex_bubble=1.
- A source "matches" an entry when all hold: the source's use flag is set, id_valid=1, entry.valid=1, entry.regwrite=1, entry.rd equals the source, and the source is nonzero. Register 0 never matches.
- Select encoding: 00 = ID/EX register value; 01 = EX/MEM ALU result; 10 = MEM/WB write-back data; 11 is reserved and never driven.
- Next select per operand, with priority:
  - Current EX entry matches -> 01.
  - Else current MEM entry matches -> 10.
  - Else 00.
- The next select is registered into fwd_x_sel on the edge the ID instruction enters EX. When EX takes a bubble, the select is registered as 00.
- Load-use: load_use_stall = EX entry matches rs or rt AND EX.memread=1 AND flush=0.
- Stall response, combinational: pc_write=0, ifid_write=0, idex_bubble=1. The ID instruction re-evaluates next cycle and resolves to select 10 via the MEM entry.
- Flush response: idex_bubble=1. pc_write and ifid_write stay 1, since the IF/ID clear is owned by the fetch logic. Flush has priority over load-use stall.
- ext_stall=1 freezes the shadow pipeline, fwd selects and stall_count. It forces pc_write=0, ifid_write=0 and idex_bubble=0. ext_stall has priority over flush and stall.
- stall_count increments by 1 on each edge where load_use_stall=1 and ext_stall=0. It saturates at all-ones.

## Timing
- Reset state:
  - All shadow entries valid=0, rd=0.
  - fwd_a_sel=fwd_b_sel=00, stall_count=0.
  - pc_write=1, ifid_write=1, idex_bubble=0, load_use_stall=0.
- fwd_x_sel: registered, 1-cycle latency from ID evaluation; stable for the whole EX cycle.
- pc_write, ifid_write, idex_bubble, load_use_stall: combinational from the ID inputs and shadow state, same cycle.
- A load-use stall lasts exactly 1 cycle per load unless ext_stall extends it. Back-to-back dependent loads each cost 1 cycle.
- rst asserted mid-stall clears all state on that edge. The first cycle after reset behaves as an empty pipeline.
- Simultaneous flush and load-use: flush wins, load_use_stall=0 and the counter does not increment.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_RSVD=2'b11.
  - Shadow-entry typedef {valid, rd, regwrite, memread}.
- One combinational sub-module, `fwd_sel_calc`: takes a source address, its use flag and the EX/MEM entries, and returns the 2-bit select and the load-hit flag. It is instantiated twice, once for rs and once for rt.

## Test plan
- ADD r3 then SUB r4,r3,r1 back-to-back -> fwd_a_sel=01 during SUB's EX cycle; no stall.
- ADD r3, NOP, then OR r5,r1,r3 -> fwd_b_sel=10 in OR's EX; fwd_a_sel=00.
- LW r2 then ADD r6,r2,r2:
  - Cycle 1: load_use_stall=1, pc_write=0, idex_bubble=1, stall_count 0->1.
  - Next cycle: both selects 10 in ADD's EX.
- Writer to r0 followed by a reader of r0 -> both selects 00, no stall.
- LW r2 with a dependent instruction in ID while flush=1 -> load_use_stall=0, idex_bubble=1, stall_count unchanged.
- ext_stall=1 for 3 cycles during a pending forward -> selects and shadow state hold, pc_write=0. On release, select 01 is applied in the correct EX cycle. rst mid-sequence -> all outputs return to reset values.
